axi4_lite_reg_slave: RTL and testbench

AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

---
 rtl/axi4_lite_reg_slave.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi4_lite_reg_slave                                        |
// | Description : AXI4-Lite slave exposing a 16-byte register window:        |
// |                 +0x0 CTRL    RW, bits [7:0] implemented (bit 0 -> led)   |
// |                 +0x4 SCRATCH RW, 32 bits, byte-strobed                   |
// |                 +0x8 COUNTER RO, free-running cycle counter              |
// |                 +0xC ID      RO, 32'h5256_0001                           |
// |               Accesses outside the window return SLVERR with rdata 0.    |
// |               Read and write channels are independent FSMs.              |
// | Config      : define AXI_REG_SLAVE_COUNTER_EN to build the counter;      |
// |               without it COUNTER reads 0 (OKAY) and has no flops.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk                   in   1          rising-edge clock                |
// |   rst                   in   1          async reset, active low          |
// |   awaddr                in   ADDR_WIDTH write address                    |
// |   awvalid / awready     in / out        AW handshake                     |
// |   wdata                 in   32         write data                       |
// |   wstrb                 in   4          byte strobes                     |
// |   wvalid / wready       in / out        W handshake                      |
// |   bresp                 out  2          write response                   |
// |   bvalid / bready       out / in        B handshake                      |
// |   araddr                in   ADDR_WIDTH read address                     |
// |   arvalid / arready     in / out        AR handshake                     |
// |   rdata                 out  32         read data                        |
// |   rresp                 out  2          read response                    |
// |   rvalid / rready       out / in        R handshake                      |
// |   led                   out  1          CTRL[0] flop                     |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   ADDR_WIDTH  AXI address width (must be greater than 4)                 |
// |   DATA_WIDTH  AXI data width, only 32 is supported                       |
// |   BASE_ADDR   base address of the register window                        |
// +--------------------------------------------------------------------------+

module axi4_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,

  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,

  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,

  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,

  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,

  output logic                    led
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  localparam logic [31:0] C_ID_VALUE = 32'h5256_0001;

  localparam logic [ADDR_WIDTH-1:0] C_WINDOW_BYTES = ADDR_WIDTH'(16);

  localparam logic [1:0] C_SEL_CTRL    = 2'd0;
  localparam logic [1:0] C_SEL_SCRATCH = 2'd1;
  localparam logic [1:0] C_SEL_COUNTER = 2'd2;
  localparam logic [1:0] C_SEL_ID      = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]  r_wstate;
  logic [0:0]  r_rstate;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [7:0]  r_ctrl;
  logic [31:0] r_scratch;

  logic [31:0] w_counter;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  // The offset is an unsigned difference, so an address below BASE_ADDR wraps
  // to a large value and fails the window check just like one above it.
  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic                  w_wr_hit;
  logic                  w_rd_hit;
  logic [1:0]            w_wr_sel;
  logic [1:0]            w_rd_sel;

  assign w_wr_off = awaddr - BASE_ADDR;
  assign w_rd_off = araddr - BASE_ADDR;
  assign w_wr_hit = (w_wr_off < C_WINDOW_BYTES);
  assign w_rd_hit = (w_rd_off < C_WINDOW_BYTES);
  assign w_wr_sel = w_wr_off[3:2];
  assign w_rd_sel = w_rd_off[3:2];

  // Byte lane within a register is irrelevant: all registers are word wide.
  logic w_unused_offset_bits;
  assign w_unused_offset_bits = ^{w_wr_off[1:0], w_rd_off[1:0]};

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  // AW and W are taken together or not at all; ready is only raised once both
  // valids are present so neither channel is ever half-accepted. Ready is held
  // low while reset is asserted.
  logic w_wr_accept;
  logic w_rd_idle;
  logic w_rd_accept;

  assign w_wr_accept = rst && (r_wstate == W_IDLE) && awvalid && wvalid;
  assign w_rd_idle   = rst && (r_rstate == R_IDLE);
  assign w_rd_accept = w_rd_idle && arvalid;

  assign awready = w_wr_accept;
  assign wready  = w_wr_accept;
  assign arready = w_rd_idle;

  // --------------------------------------------------------------------------
  // Free-running counter (optional)
  // --------------------------------------------------------------------------
`ifdef AXI_REG_SLAVE_COUNTER_EN
  logic [31:0] r_counter;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_counter <= 32'h0;
    end else begin
      r_counter <= r_counter + 32'd1;
    end
  end

  assign w_counter = r_counter;
`else
  assign w_counter = 32'h0;
`endif

  // --------------------------------------------------------------------------
  // RW registers
  // --------------------------------------------------------------------------
  // Only in-window writes to CTRL/SCRATCH touch state; writes to the read-only
  // registers and out-of-window writes still complete but change nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl    <= 8'h00;
      r_scratch <= 32'h0;
    end else if (w_wr_accept && w_wr_hit) begin
      case (w_wr_sel)
        C_SEL_CTRL: begin
          if (wstrb[0]) begin
            r_ctrl <= wdata[7:0];
          end
        end
        C_SEL_SCRATCH: begin
          for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
              r_scratch[8*i +: 8] <= wdata[8*i +: 8];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign led = r_ctrl[0];

  // --------------------------------------------------------------------------
  // Write response FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_bvalid <= 1'b0;
      r_bresp  <= C_RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_accept) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_hit ? C_RESP_OKAY : C_RESP_SLVERR;
          end
        end
        W_RESP: begin
          // bresp is left as-is; only bvalid drops once the master takes it.
          if (bready) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
          r_bvalid <= 1'b0;
        end
      endcase
    end
  end

  assign bvalid = r_bvalid;
  assign bresp  = r_bresp;

  // --------------------------------------------------------------------------
  // Read data selection
  // --------------------------------------------------------------------------
  // Sampled from the current flop values, so a write accepted in the same
  // cycle is not yet visible and the read returns the pre-write contents.
  logic [31:0] w_rd_value;

  always_comb begin
    w_rd_value = 32'h0;
    case (w_rd_sel)
      C_SEL_CTRL:    w_rd_value = {24'h0, r_ctrl};
      C_SEL_SCRATCH: w_rd_value = r_scratch;
      C_SEL_COUNTER: w_rd_value = w_counter;
      C_SEL_ID:      w_rd_value = C_ID_VALUE;
      default:       w_rd_value = 32'h0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read response FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rresp  <= C_RESP_OKAY;
      r_rdata  <= 32'h0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_accept) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_hit ? C_RESP_OKAY : C_RESP_SLVERR;
            r_rdata  <= w_rd_hit ? w_rd_value  : 32'h0;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign rvalid = r_rvalid;
  assign rresp  = r_rresp;
  assign rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axi4_lite_reg_slave                                     |
// | Description : Scoreboard bench for axi4_lite_reg_slave. A negedge        |
// |               monitor pushes expected responses from a register-map      |
// |               model on each accepted request and pops/compares them on   |
// |               each B/R handshake. Honours AXI_REG_SLAVE_COUNTER_EN.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

module tb_axi4_lite_reg_slave;

  localparam int          AW      = 32;
  localparam logic [31:0] BASE    = 32'h4000_1000;
  localparam logic [31:0] ID_WORD = 32'h5256_0001;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        led;

  axi4_lite_reg_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running edge count; the expected COUNTER value is the number of
  // rising edges seen since reset was last released.
  logic [31:0] cyc     = 32'h0;
  logic [31:0] rel_cyc = 32'h0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [31:0] m_ctrl    = 32'h0;
  logic [31:0] m_scratch = 32'h0;
  rd_exp_t     rq[$];
  logic [1:0]  bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  function automatic logic [31:0] exp_counter();
`ifdef AXI_REG_SLAVE_COUNTER_EN
    return cyc - rel_cyc;
`else
    return 32'h0;
`endif
  endfunction

  function automatic rd_exp_t model_read(input logic [31:0] a);
    rd_exp_t     r;
    logic [31:0] off;
    off = a - BASE;
    r.resp = 2'b00;
    r.data = 32'h0;
    if (off >= 32'd16) begin
      r.resp = 2'b10;
    end else begin
      case (off / 4)
        0:       r.data = m_ctrl;
        1:       r.data = m_scratch;
        2:       r.data = exp_counter();
        default: r.data = ID_WORD;
      endcase
    end
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off;
    off = a - BASE;
    if (off == 32'd0 || off == 32'd1 || off == 32'd2 || off == 32'd3) begin
      if (s[0]) m_ctrl = {24'h0, d[7:0]};
    end else if (off >= 32'd4 && off < 32'd8) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        pb_valid = 1'b0, pb_ready = 1'b0;
  logic [1:0]  pb_resp  = 2'b00;
  logic        pr_valid = 1'b0, pr_ready = 1'b0;
  logic [1:0]  pr_resp  = 2'b00;
  logic [31:0] pr_data  = 32'h0;

  always @(negedge clk) begin
    rd_exp_t    er;
    logic [1:0] eb;
    if (!rst) begin
      chk("rst_bvalid",  32'(bvalid),  32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready",  32'(wready),  32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_led",     32'(led),     32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_bresp",   32'(bresp),   32'd0);
      chk("rst_rresp",   32'(rresp),   32'd0);
      rq.delete();
      bq.delete();
      m_ctrl    = 32'h0;
      m_scratch = 32'h0;
      pb_valid  = 1'b0;
      pr_valid  = 1'b0;
    end else begin
      if (pb_valid && !pb_ready) begin
        chk("b_hold_valid", 32'(bvalid), 32'd1);
        chk("b_hold_resp",  32'(bresp),  32'(pb_resp));
      end
      if (pr_valid && !pr_ready) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data",  rdata,       pr_data);
        chk("r_hold_resp",  32'(rresp),  32'(pr_resp));
      end
      if (bvalid) begin
        chk("awready_busy", 32'(awready), 32'd0);
        chk("wready_busy",  32'(wready),  32'd0);
      end else begin
        chk("awready_idle", 32'(awready), 32'(awvalid && wvalid));
        chk("wready_idle",  32'(wready),  32'(awvalid && wvalid));
      end
      chk("arready", 32'(arready), 32'(!rvalid));
      chk("led", 32'(led), 32'(m_ctrl[0]));

      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          tmo("b_unexpected");
        end else begin
          eb = bq.pop_front();
          chk("bresp", 32'(bresp), 32'(eb));
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          tmo("r_unexpected");
        end else begin
          er = rq.pop_front();
          chk("rdata", rdata, er.data);
          chk("rresp", 32'(rresp), 32'(er.resp));
        end
      end

      // Reads are modelled before writes: same-cycle read sees old contents.
      if (arvalid && arready) rq.push_back(model_read(araddr));
      if (awvalid && awready) begin
        bq.push_back(((awaddr - BASE) < 32'd16) ? 2'b00 : 2'b10);
        model_write(awaddr, wdata, wstrb);
      end

      pb_valid = bvalid; pb_ready = bready; pb_resp = bresp;
      pr_valid = rvalid; pr_ready = rready; pr_resp = rresp; pr_data = rdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly, input int wlag);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1;
    wvalid  = (wlag == 0);
    for (int i = 0; i < wlag; i++) begin @(posedge clk); #1; end
    wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      tmo("aw_accept");
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_latency", 32'(bvalid), 32'd1);
    for (int i = 0; i < bdly; i++) begin @(posedge clk); #1; end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_done", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdly,
                          output logic [31:0] d, output logic [31:0] acc);
    int n;
    d = 32'h0; acc = 32'h0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      tmo("ar_accept");
      @(posedge clk); #1; arvalid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_latency", 32'(rvalid), 32'd1);
    d = rdata;
    for (int i = 0; i < rdly; i++) begin @(posedge clk); #1; end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("r_done", 32'(rvalid), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rel_cyc = cyc;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'($urandom_range(1, 8));
      1:       return BASE + 32'($urandom_range(16, 64));
      default: return BASE + 32'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d1, d2, a1, a2, dd;
    logic [31:0] ra, wa, wd;
    logic [3:0]  ws;
    int n;

    rst = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rel_cyc = cyc;

    // CTRL write lights the led
    axi_write(BASE + 32'h0, 32'h0000_0001, 4'hF, 0, 0);
    chk("led_on", 32'(led), 32'd1);

    // partial strobes into SCRATCH after a fresh reset
    do_reset();
    axi_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, 1, 0);
    axi_read(BASE + 32'h4, 0, d1, a1);
    chk("scratch_strb", d1, 32'h00BB_00DD);

    // ID read held off for 5 cycles
    axi_read(BASE + 32'hC, 5, d1, a1);
    chk("id_value", d1, ID_WORD);

    // decode errors leave the map untouched
    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(BASE + 32'h20, 0, d1, a1);
    axi_read(BASE + 32'h4, 0, d1, a1);
    axi_read(BASE + 32'h0, 0, d1, a1);

    // zero strobes, RO writes, W arriving after AW
    axi_write(BASE + 32'h4, 32'h1234_5678, 4'h0, 0, 0);
    axi_write(BASE + 32'hC, 32'h1234_5678, 4'hF, 0, 0);
    axi_write(BASE + 32'h8, 32'h1234_5678, 4'hF, 2, 0);
    axi_write(BASE + 32'h1, 32'h0000_00A5, 4'h1, 0, 2);
    axi_read(BASE + 32'hE, 0, d1, a1);

    // counter read twice, some cycles apart
    axi_read(BASE + 32'h8, 0, d1, a1);
    repeat (7) @(posedge clk);
    axi_read(BASE + 32'h8, 2, d2, a2);
`ifdef AXI_REG_SLAVE_COUNTER_EN
    chk("counter_delta", d2 - d1, a2 - a1);
`else
    chk("counter_zero_a", d1, 32'h0);
    chk("counter_zero_b", d2, 32'h0);
`endif

    // same-cycle write and read of SCRATCH returns the old value
    fork
      axi_write(BASE + 32'h4, 32'hCAFE_F00D, 4'hF, 0, 0);
      axi_read(BASE + 32'h4, 0, d1, a1);
    join
    chk("rw_old_value", d1, 32'h00BB_00DD);

    // reset while a write response is pending
    @(posedge clk); #1;
    awaddr = BASE + 32'h4; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) tmo("aw_accept_rst");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_pending", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_async_bvalid", 32'(bvalid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rel_cyc = cyc;
    axi_write(BASE + 32'h4, 32'h0F0F_0F0F, 4'hF, 0, 0);
    axi_read(BASE + 32'h4, 0, d1, a1);
    chk("post_rst_write", d1, 32'h0F0F_0F0F);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      ra = rand_addr();
      wa = rand_addr();
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 1));
        1: axi_read(ra, $urandom_range(0, 3), dd, a1);
        default: begin
          fork
            axi_write(wa, wd, ws, $urandom_range(0, 3), 0);
            axi_read(ra, $urandom_range(0, 3), dd, a2);
          join
        end
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    tmo("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
